// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the runtime-programmable clock divider.
package clk_div_pkg;

   localparam int DIV_CNT_W    = 8;
   localparam int DIV_DEF_HALF = 16;

   // Legacy state encodings, kept stable for anything that decodes them.
   localparam logic [1:0] S_OFF      = 2'd0;
   localparam logic [1:0] S_RUN      = 2'd1;
   localparam logic [1:0] S_STOPPING = 2'd2;

   typedef enum logic [1:0] {
      OFF      = S_OFF,
      RUN      = S_RUN,
      STOPPING = S_STOPPING
   } div_state_e;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter, clk_out toggle and tick generation.
// load holds the counter and output cleared; otherwise it counts to half-1.
module clk_div_core #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] half,
   output logic             clk_out,
   output logic             tick,
   output logic             boundary
);

   logic [CNT_W-1:0] cnt;
   logic             terminal;

   assign terminal = (cnt == half - CNT_W'(1));
   // Falling toggle of clk_out happens at the next edge: a period boundary.
   assign boundary = !load && clk_out && terminal;

   // Count within a half-period and toggle the divided clock at its end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (load) begin
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (terminal) begin
         cnt     <= '0;
         clk_out <= ~clk_out;
         tick    <= ~clk_out;
      end else begin
         cnt     <= cnt + CNT_W'(1);
         tick    <= 1'b0;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: run/stop sequencing, config handshake and
// boundary-aligned application of new half-periods.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int CNT_W    = DIV_CNT_W,
   parameter int DEF_HALF = DIV_DEF_HALF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             running,
   output logic [CNT_W-1:0] cur_half
);

   div_state_e       state, state_nx;
   logic [CNT_W-1:0] pend;
   logic             pend_v;
   logic             load;
   logic             boundary;
   logic             accept;
   logic             apply;

   clk_div_core #(
      .CNT_W(CNT_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .half    (cur_half),
      .clk_out (clk_out),
      .tick    (tick),
      .boundary(boundary)
   );

   // A low phase may be cut short on stop; a high phase never is.
   assign load      = (state == OFF) || (state == RUN && !en && !clk_out);
   assign cfg_ready = !pend_v;
   assign running   = (state != OFF);
   assign accept    = cfg_valid && !pend_v;
   // pend_v is the pre-edge value, so a same-cycle transfer waits a boundary.
   assign apply     = pend_v && ((state == OFF) || boundary);

   // Next-state selection for run/stop sequencing.
   always_comb begin
      state_nx = state;
      case (state)
         OFF:      state_nx = en ? RUN : OFF;
         RUN: begin
            if (!en) begin
               if (!clk_out || boundary) state_nx = OFF;
               else                      state_nx = STOPPING;
            end
         end
         STOPPING: state_nx = boundary ? OFF : STOPPING;
         default:  state_nx = OFF;
      endcase
   end

   // State, pending config register, error pulse and half-period in effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= OFF;
         pend     <= '0;
         pend_v   <= 1'b0;
         cfg_err  <= 1'b0;
         cur_half <= CNT_W'(DEF_HALF);
      end else begin
         state   <= state_nx;
         cfg_err <= accept && (cfg_half == '0);
         if (apply) begin
            cur_half <= pend;
            pend_v   <= 1'b0;
         end
         if (accept && (cfg_half != '0)) begin
            pend   <= cfg_half;
            pend_v <= 1'b1;
         end
      end
   end

endmodule
